// File: rtl/rx_dc_cal_ctrl.sv
// RX DC-offset calibration sequencer: settle, average 2^LOG_N I/Q samples, write the
// negated means to the frontend offset registers over a settings bus shared with the host.
module rx_dc_cal_ctrl #(
  parameter int BASE       = 0,
  parameter int LOG_N      = 10,
  parameter int SETTLE_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        smp_stb,
  input  logic [23:0] i_in,
  input  logic [23:0] q_in,
  input  logic        host_stb,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        busy,
  output logic        done,
  output logic [23:0] mean_i,
  output logic [23:0] mean_q
);

  localparam int AW = 24 + LOG_N;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] SMP_LAST    = 32'((1 << LOG_N) - 1);
  localparam logic [7:0]  ADDR_I      = 8'(BASE + 3);
  localparam logic [7:0]  ADDR_Q      = 8'(BASE + 4);

  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, CALC, WR_I, WR_Q} state_t;

  state_t             state_q;
  logic [31:0]        cnt_q;
  logic signed [AW-1:0] acc_i_q, acc_q_q;
  logic [23:0]        corr_i_q, corr_q_q;
  logic [23:0]        mi_d, mq_d, ci_d, cq_d;

  // Bits above the binary point of the accumulator are exactly acc >>> LOG_N (floor).
  assign mi_d = acc_i_q[LOG_N +: 24];
  assign mq_d = acc_q_q[LOG_N +: 24];
  // Negating -2^23 would wrap, so pin it to the most positive correction.
  assign ci_d = (mi_d == 24'h800000) ? 24'h7FFFFF : 24'd0 - mi_d;
  assign cq_d = (mq_d == 24'h800000) ? 24'h7FFFFF : 24'd0 - mq_d;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      corr_i_q <= '0;
      corr_q_q <= '0;
      mean_i   <= '0;
      mean_q   <= '0;
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      set_stb <= 1'b0;
      // Host always wins the bus; an internal write simply waits in its state.
      if (host_stb) begin
        set_stb  <= 1'b1;
        set_addr <= host_addr;
        set_data <= host_data;
      end else if (!abort && state_q == WR_I) begin
        set_stb  <= 1'b1;
        set_addr <= ADDR_I;
        set_data <= {1'b1, 7'd0, corr_i_q};
      end else if (!abort && state_q == WR_Q) begin
        set_stb  <= 1'b1;
        set_addr <= ADDR_Q;
        set_data <= {1'b1, 7'd0, corr_q_q};
      end

      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
          end
          SETTLE: if (cnt_q == SETTLE_LAST) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
          ACCUM: if (smp_stb) begin
            acc_i_q <= acc_i_q + {{LOG_N{i_in[23]}}, i_in};
            acc_q_q <= acc_q_q + {{LOG_N{q_in[23]}}, q_in};
            if (cnt_q == SMP_LAST) begin
              state_q <= CALC;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          CALC: begin
            mean_i   <= mi_d;
            mean_q   <= mq_d;
            corr_i_q <= ci_d;
            corr_q_q <= cq_d;
            state_q  <= WR_I;
          end
          WR_I: if (!host_stb) state_q <= WR_Q;
          WR_Q: if (!host_stb) begin
            state_q <= IDLE;
            done    <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
